// File: rtl/wr_arb_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
package wr_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_e;

    localparam int STALL_CNT_W = 16;
    localparam int MAX_REQ     = 8;

    // Lowest set bit wins; callers only pass one-hot or zero vectors.
    function automatic logic [2:0] onehot_to_idx(input logic [MAX_REQ-1:0] oh);
        logic [2:0] idx;
        idx = '0;
        for (int i = MAX_REQ - 1; i >= 0; i--) begin
            if (oh[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/wr_port_arbiter_if.sv
// Requester-side and FIFO-side write signals of the arbiter, bundled.
interface wr_port_arbiter_if #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_SIZE = 8
);
    import wr_arb_pkg::*;

    logic [NUM_REQ-1:0]           req_valid;
    logic [NUM_REQ*DATA_SIZE-1:0] req_data;
    logic [NUM_REQ-1:0]           req_ack;
    logic [NUM_REQ-1:0]           gnt;
    logic                         wr_full;
    logic                         wr_inc;
    logic [DATA_SIZE-1:0]         wr_data;

    modport master (
        input  req_valid, req_data, wr_full,
        output req_ack, gnt, wr_inc, wr_data
    );

    modport slave (
        output req_valid, req_data, wr_full,
        input  req_ack, gnt, wr_inc, wr_data
    );

endinterface

// File: rtl/wr_port_arbiter_rr_pick.sv
// Round-robin pick: first valid requester at or after rr_ptr, circularly.
module rr_pick
    import wr_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    localparam int IDX_W  = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic [NUM_REQ-1:0] winner,
    output logic               any_req
);

    logic [NUM_REQ-1:0] rot;
    logic [NUM_REQ-1:0] pe;
    logic               found;

    // Rotate so rr_ptr lands at bit 0, take the lowest set bit, rotate back.
    always_comb begin
        rot    = '0;
        pe     = '0;
        winner = '0;
        found  = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            int j;
            j = i + int'(rr_ptr);
            if (j >= NUM_REQ) j = j - NUM_REQ;
            rot[i] = req_valid[j];
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (rot[i] && !found) begin
                pe[i] = 1'b1;
                found = 1'b1;
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            int j;
            j = i + int'(rr_ptr);
            if (j >= NUM_REQ) j = j - NUM_REQ;
            winner[j] = pe[i];
        end
    end

    assign any_req = |req_valid;

endmodule

// File: rtl/wr_port_arbiter.sv
// Round-robin, burst-holding arbiter for the async FIFO write port.
// Optional stall counter output enabled by defining WR_ARB_STALL_CNT_EN.
module wr_port_arbiter
    import wr_arb_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int DATA_SIZE = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                   wr_clk,
    input  logic                   wr_rst,
    wr_port_arbiter_if.master      bus
`ifdef WR_ARB_STALL_CNT_EN
    ,
    output logic [STALL_CNT_W-1:0] stall_cnt
`endif
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_BURST) + 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_REQ - 1);

    arb_state_e         state_q;
    logic [NUM_REQ-1:0] gnt_q;
    logic [CNT_W-1:0]   burst_cnt_q, burst_cnt_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;

    logic [NUM_REQ-1:0] winner;
    logic               any_req;
    logic [IDX_W-1:0]   g_idx;
    logic               granted;
    logic               g_valid;
    logic               accept;

    rr_pick #(.NUM_REQ(NUM_REQ)) u_rr_pick (
        .req_valid (bus.req_valid),
        .rr_ptr    (rr_ptr_q),
        .winner    (winner),
        .any_req   (any_req)
    );

    assign g_idx   = IDX_W'(onehot_to_idx(MAX_REQ'(gnt_q)));
    assign granted = |gnt_q;
    assign g_valid = granted & bus.req_valid[g_idx];
    // Full is registered in the FIFO, so gating on it here never loses a word.
    assign accept  = g_valid & ~bus.wr_full;

    assign bus.gnt     = gnt_q;
    assign bus.wr_inc  = accept;
    assign bus.req_ack = accept ? gnt_q : '0;
    assign bus.wr_data = granted ? bus.req_data[g_idx*DATA_SIZE +: DATA_SIZE] : '0;

    assign burst_cnt_d = burst_cnt_q + 1'b1;
    assign rr_ptr_d    = (g_idx == LAST_IDX) ? '0 : g_idx + 1'b1;

    always_ff @(posedge wr_clk or negedge wr_rst) begin
        if (!wr_rst) begin
            state_q     <= IDLE;
            gnt_q       <= '0;
            burst_cnt_q <= '0;
            rr_ptr_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (any_req) begin
                        gnt_q   <= winner;
                        state_q <= BURST;
                    end
                end
                BURST: begin
                    // Release on dropped valid or on the last beat of the burst.
                    if (!g_valid || (accept && burst_cnt_q == LAST_BEAT)) begin
                        state_q     <= IDLE;
                        gnt_q       <= '0;
                        burst_cnt_q <= '0;
                        rr_ptr_q    <= rr_ptr_d;
                    end else if (accept) begin
                        burst_cnt_q <= burst_cnt_d;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    gnt_q   <= '0;
                end
            endcase
        end
    end

`ifdef WR_ARB_STALL_CNT_EN
    logic                   stall;
    logic [STALL_CNT_W-1:0] stall_cnt_q;

    assign stall     = (state_q == BURST) & g_valid & bus.wr_full;
    assign stall_cnt = stall_cnt_q;

    always_ff @(posedge wr_clk or negedge wr_rst) begin
        if (!wr_rst) begin
            stall_cnt_q <= '0;
        end else if (stall && stall_cnt_q != {STALL_CNT_W{1'b1}}) begin
            stall_cnt_q <= stall_cnt_q + 1'b1;
        end
    end
`endif

endmodule
